// File: rtl/alu_reservation_station_if.sv
// rtl/alu_reservation_station_if.sv - dispatch, result broadcast and ALU issue bundle for the ALU reservation station
interface alu_reservation_station_if #(
    parameter int OP_W  = 6,
    parameter int TAG_W = 5
);
    // Dispatch request from the decode/rename stage
    logic             dis_valid;
    logic [OP_W-1:0]  dis_op;
    logic [31:0]      dis_vi;
    logic [31:0]      dis_vj;
    logic             dis_qi_busy;
    logic             dis_qj_busy;
    logic [TAG_W-1:0] dis_qi;
    logic [TAG_W-1:0] dis_qj;
    logic [31:0]      dis_imm;
    logic [31:0]      dis_pc;
    logic             dis_itype;
    logic [TAG_W-1:0] dis_rob;
    logic             full;

    // Result broadcasts from the ALU and the load/store buffer
    logic             alu_cdb_valid;
    logic [TAG_W-1:0] alu_cdb_tag;
    logic [31:0]      alu_cdb_val;
    logic             lsb_cdb_valid;
    logic [TAG_W-1:0] lsb_cdb_tag;
    logic [31:0]      lsb_cdb_val;

    // Registered issue port into the ALU
    logic [OP_W-1:0]  alu_op;
    logic [31:0]      alu_vi;
    logic [31:0]      alu_vj;
    logic [31:0]      alu_imm;
    logic [31:0]      alu_pc;
    logic [TAG_W-1:0] alu_rd;
    logic             alu_itype;

    modport master (
        output dis_valid, dis_op, dis_vi, dis_vj, dis_qi_busy, dis_qj_busy,
               dis_qi, dis_qj, dis_imm, dis_pc, dis_itype, dis_rob,
               alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
               lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val,
        input  full, alu_op, alu_vi, alu_vj, alu_imm, alu_pc, alu_rd, alu_itype
    );

    modport slave (
        input  dis_valid, dis_op, dis_vi, dis_vj, dis_qi_busy, dis_qj_busy,
               dis_qi, dis_qj, dis_imm, dis_pc, dis_itype, dis_rob,
               alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
               lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val,
        output full, alu_op, alu_vi, alu_vj, alu_imm, alu_pc, alu_rd, alu_itype
    );
endinterface

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - operand-capturing reservation station feeding the integer ALU
module alu_reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int OP_W    = 6,
    parameter int TAG_W   = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    alu_reservation_station_if.slave rs
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Per-entry state; single-bit fields are packed so full/ready reduce cleanly
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qi_busy;
    logic [RS_SIZE-1:0] qj_busy;
    logic [RS_SIZE-1:0] itype;
    logic [OP_W-1:0]    op  [RS_SIZE];
    logic [31:0]        vi  [RS_SIZE];
    logic [31:0]        vj  [RS_SIZE];
    logic [TAG_W-1:0]   qi  [RS_SIZE];
    logic [TAG_W-1:0]   qj  [RS_SIZE];
    logic [31:0]        imm [RS_SIZE];
    logic [31:0]        pc  [RS_SIZE];
    logic [TAG_W-1:0]   rob [RS_SIZE];

    // Registered issue port
    logic [OP_W-1:0]    alu_op_q;
    logic [31:0]        alu_vi_q;
    logic [31:0]        alu_vj_q;
    logic [31:0]        alu_imm_q;
    logic [31:0]        alu_pc_q;
    logic [TAG_W-1:0]   alu_rd_q;
    logic               alu_itype_q;

    logic               full_w;
    logic               dis_fire;
    logic [RS_SIZE-1:0] ready;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;

    // Dispatch operands after same-cycle broadcast bypass
    logic               dis_qi_busy_eff;
    logic               dis_qj_busy_eff;
    logic [31:0]        dis_vi_eff;
    logic [31:0]        dis_vj_eff;

    // Occupancy and eligibility come from the current state only, so an
    // entry written or woken this cycle cannot issue until the next one
    assign full_w   = &busy;
    assign ready    = busy & ~qi_busy & ~qj_busy;
    assign dis_fire = rs.dis_valid && !full_w;

    // Lowest-index free entry for dispatch
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = i[IDX_W-1:0];
            end
        end
    end

    // Lowest-index ready entry for issue
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = i[IDX_W-1:0];
            end
        end
    end

    // Bypass a broadcast that lands in the dispatch cycle; the ALU port wins a tie
    always_comb begin
        dis_qi_busy_eff = rs.dis_qi_busy;
        dis_vi_eff      = rs.dis_vi;
        dis_qj_busy_eff = rs.dis_qj_busy;
        dis_vj_eff      = rs.dis_vj;
        if (rs.dis_qi_busy) begin
            if (rs.alu_cdb_valid && rs.alu_cdb_tag == rs.dis_qi) begin
                dis_qi_busy_eff = 1'b0;
                dis_vi_eff      = rs.alu_cdb_val;
            end else if (rs.lsb_cdb_valid && rs.lsb_cdb_tag == rs.dis_qi) begin
                dis_qi_busy_eff = 1'b0;
                dis_vi_eff      = rs.lsb_cdb_val;
            end
        end
        if (rs.dis_qj_busy) begin
            if (rs.alu_cdb_valid && rs.alu_cdb_tag == rs.dis_qj) begin
                dis_qj_busy_eff = 1'b0;
                dis_vj_eff      = rs.alu_cdb_val;
            end else if (rs.lsb_cdb_valid && rs.lsb_cdb_tag == rs.dis_qj) begin
                dis_qj_busy_eff = 1'b0;
                dis_vj_eff      = rs.lsb_cdb_val;
            end
        end
    end

    // Entry state: reset/flush clear, otherwise wakeup, issue and dispatch
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy    <= '0;
            qi_busy <= '0;
            qj_busy <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && qi_busy[i]) begin
                        if (rs.alu_cdb_valid && rs.alu_cdb_tag == qi[i]) begin
                            vi[i]      <= rs.alu_cdb_val;
                            qi_busy[i] <= 1'b0;
                        end else if (rs.lsb_cdb_valid && rs.lsb_cdb_tag == qi[i]) begin
                            vi[i]      <= rs.lsb_cdb_val;
                            qi_busy[i] <= 1'b0;
                        end
                    end
                    if (busy[i] && qj_busy[i]) begin
                        if (rs.alu_cdb_valid && rs.alu_cdb_tag == qj[i]) begin
                            vj[i]      <= rs.alu_cdb_val;
                            qj_busy[i] <= 1'b0;
                        end else if (rs.lsb_cdb_valid && rs.lsb_cdb_tag == qj[i]) begin
                            vj[i]      <= rs.lsb_cdb_val;
                            qj_busy[i] <= 1'b0;
                        end
                    end
                end
                // Issued entry frees on the same edge it loads the ALU
                if (sel_found) begin
                    busy[sel_idx] <= 1'b0;
                end
                // Dispatch targets a free slot, never the one just issued
                if (dis_fire && free_found) begin
                    busy[free_idx]    <= 1'b1;
                    op[free_idx]      <= rs.dis_op;
                    vi[free_idx]      <= dis_vi_eff;
                    vj[free_idx]      <= dis_vj_eff;
                    qi_busy[free_idx] <= dis_qi_busy_eff;
                    qj_busy[free_idx] <= dis_qj_busy_eff;
                    qi[free_idx]      <= rs.dis_qi;
                    qj[free_idx]      <= rs.dis_qj;
                    imm[free_idx]     <= rs.dis_imm;
                    pc[free_idx]      <= rs.dis_pc;
                    itype[free_idx]   <= rs.dis_itype;
                    rob[free_idx]     <= rs.dis_rob;
                end
            end
        end
    end

    // Issue register: idle cycles drop alu_op but keep the operand fields
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_op_q    <= '0;
            alu_vi_q    <= '0;
            alu_vj_q    <= '0;
            alu_imm_q   <= '0;
            alu_pc_q    <= '0;
            alu_rd_q    <= '0;
            alu_itype_q <= 1'b0;
        end else if (rdy_in) begin
            if (flush || !sel_found) begin
                alu_op_q <= '0;
            end else begin
                alu_op_q    <= op[sel_idx];
                alu_vi_q    <= vi[sel_idx];
                alu_vj_q    <= vj[sel_idx];
                alu_imm_q   <= imm[sel_idx];
                alu_pc_q    <= pc[sel_idx];
                alu_rd_q    <= rob[sel_idx];
                alu_itype_q <= itype[sel_idx];
            end
        end
    end

    assign rs.full      = full_w;
    assign rs.alu_op    = alu_op_q;
    assign rs.alu_vi    = alu_vi_q;
    assign rs.alu_vj    = alu_vj_q;
    assign rs.alu_imm   = alu_imm_q;
    assign rs.alu_pc    = alu_pc_q;
    assign rs.alu_rd    = alu_rd_q;
    assign rs.alu_itype = alu_itype_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - directed self-checking bench for the ALU reservation station
module tb_alu_reservation_station;
    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic flush;
    int   total;
    int   bad;

    alu_reservation_station_if #(.OP_W(6), .TAG_W(5)) bus ();

    alu_reservation_station #(.RS_SIZE(8), .OP_W(6), .TAG_W(5)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .rs     (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic dis(input logic [5:0] op, input logic [31:0] vi, input logic [31:0] vj,
                       input logic qib, input logic [4:0] qi,
                       input logic qjb, input logic [4:0] qj, input logic [4:0] rob);
        bus.dis_valid   = 1'b1;
        bus.dis_op      = op;
        bus.dis_vi      = vi;
        bus.dis_vj      = vj;
        bus.dis_qi_busy = qib;
        bus.dis_qi      = qi;
        bus.dis_qj_busy = qjb;
        bus.dis_qj      = qj;
        bus.dis_imm     = 32'h1000 + {27'd0, rob};
        bus.dis_pc      = 32'h8000 + {25'd0, rob, 2'b00};
        bus.dis_itype   = rob[0];
        bus.dis_rob     = rob;
    endtask

    task automatic no_dis();
        bus.dis_valid = 1'b0;
    endtask

    task automatic alu_cdb(input logic [4:0] tag, input logic [31:0] val);
        bus.alu_cdb_valid = 1'b1;
        bus.alu_cdb_tag   = tag;
        bus.alu_cdb_val   = val;
    endtask

    task automatic lsb_cdb(input logic [4:0] tag, input logic [31:0] val);
        bus.lsb_cdb_valid = 1'b1;
        bus.lsb_cdb_tag   = tag;
        bus.lsb_cdb_val   = val;
    endtask

    task automatic no_cdb();
        bus.alu_cdb_valid = 1'b0;
        bus.lsb_cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL reset_op got=%0d exp=0", bus.alu_op); end
        total++; if (bus.alu_vi !== 32'd0) begin bad++; $display("FAIL reset_vi got=%0h exp=0", bus.alu_vi); end
        total++; if (bus.alu_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", bus.alu_rd); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
    endtask

    task automatic test_single();
        dis(6'd1, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
        step();
        no_dis();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL single_early got=%0d exp=0", bus.alu_op); end
        step();
        total++; if (bus.alu_op !== 6'd1) begin bad++; $display("FAIL single_op got=%0d exp=1", bus.alu_op); end
        total++; if (bus.alu_vi !== 32'd5 || bus.alu_vj !== 32'd7) begin bad++; $display("FAIL single_vals got=%0d,%0d exp=5,7", bus.alu_vi, bus.alu_vj); end
        total++; if (bus.alu_rd !== 5'd3) begin bad++; $display("FAIL single_rd got=%0d exp=3", bus.alu_rd); end
        total++; if (bus.alu_imm !== 32'h1003 || bus.alu_pc !== 32'h800c || bus.alu_itype !== 1'b1) begin
            bad++; $display("FAIL single_fields got=%0h,%0h,%0b exp=1003,800c,1", bus.alu_imm, bus.alu_pc, bus.alu_itype); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL single_full got=%0b exp=0", bus.full); end
        step();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL single_idle got=%0d exp=0", bus.alu_op); end
        total++; if (bus.alu_vi !== 32'd5) begin bad++; $display("FAIL single_hold got=%0d exp=5", bus.alu_vi); end
    endtask

    task automatic test_wakeup();
        dis(6'd2, 32'd0, 32'd1, 1'b1, 5'd4, 1'b0, 5'd0, 5'd5);
        step();
        no_dis();
        for (int c = 1; c <= 2; c++) begin
            step();
            total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL wake_wait%0d got=%0d exp=0", c, bus.alu_op); end
        end
        alu_cdb(5'd4, 32'd10);
        step();
        no_cdb();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL wake_same_cycle got=%0d exp=0", bus.alu_op); end
        step();
        total++; if (bus.alu_op !== 6'd2 || bus.alu_vi !== 32'd10 || bus.alu_vj !== 32'd1 || bus.alu_rd !== 5'd5) begin
            bad++; $display("FAIL wake_issue got=%0d,%0d,%0d,%0d exp=2,10,1,5", bus.alu_op, bus.alu_vi, bus.alu_vj, bus.alu_rd); end
        dis(6'd2, 32'd0, 32'd1, 1'b1, 5'd4, 1'b0, 5'd0, 5'd6);
        alu_cdb(5'd4, 32'd11);
        step();
        no_dis();
        no_cdb();
        step();
        total++; if (bus.alu_op !== 6'd2 || bus.alu_vi !== 32'd11 || bus.alu_rd !== 5'd6) begin
            bad++; $display("FAIL bypass_i got=%0d,%0d,%0d exp=2,11,6", bus.alu_op, bus.alu_vi, bus.alu_rd); end
        dis(6'd2, 32'd3, 32'd0, 1'b0, 5'd0, 1'b1, 5'd8, 5'd7);
        lsb_cdb(5'd8, 32'd12);
        step();
        no_dis();
        no_cdb();
        step();
        total++; if (bus.alu_vj !== 32'd12 || bus.alu_vi !== 32'd3 || bus.alu_rd !== 5'd7) begin
            bad++; $display("FAIL bypass_j got=%0d,%0d,%0d exp=3,12,7", bus.alu_vi, bus.alu_vj, bus.alu_rd); end
        step();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL wake_drain got=%0d exp=0", bus.alu_op); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            dis(6'd3, 32'd0, 32'(k + 100), 1'b1, 5'd9, 1'b0, 5'd0, 5'(k));
            step();
            total++; if (bus.full !== (k == 7)) begin bad++; $display("FAIL fill_full%0d got=%0b exp=%0b", k, bus.full, (k == 7)); end
        end
        dis(6'd3, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd20);
        step();
        no_dis();
        total++; if (bus.full !== 1'b1 || bus.alu_op !== 6'd0) begin bad++; $display("FAIL fill_drop got=%0b,%0d exp=1,0", bus.full, bus.alu_op); end
        lsb_cdb(5'd9, 32'd2);
        step();
        no_cdb();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL fill_wake got=%0d exp=0", bus.alu_op); end
        for (int k = 0; k < 8; k++) begin
            step();
            total++; if (bus.alu_op !== 6'd3 || bus.alu_rd !== 5'(k) || bus.alu_vi !== 32'd2 || bus.alu_vj !== 32'(k + 100)) begin
                bad++; $display("FAIL fill_issue%0d got=%0d,%0d,%0d,%0d exp=3,%0d,2,%0d", k, bus.alu_op, bus.alu_rd, bus.alu_vi, bus.alu_vj, k, k + 100); end
        end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL fill_empty got=%0b exp=0", bus.full); end
        step();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL fill_drain got=%0d exp=0", bus.alu_op); end
    endtask

    task automatic test_priority();
        dis(6'd4, 32'd0, 32'd0, 1'b1, 5'd6, 1'b0, 5'd0, 5'd16);
        step();
        for (int k = 1; k <= 5; k++) begin
            dis(6'd4, 32'd0, 32'(k), 1'b1, (k == 2 || k == 5) ? 5'd7 : 5'd12, 1'b0, 5'd0, 5'(16 + k));
            step();
        end
        no_dis();
        alu_cdb(5'd6, 32'd1);
        lsb_cdb(5'd6, 32'd2);
        step();
        no_cdb();
        step();
        total++; if (bus.alu_op !== 6'd4 || bus.alu_vi !== 32'd1 || bus.alu_rd !== 5'd16) begin
            bad++; $display("FAIL prio_dual got=%0d,%0d,%0d exp=4,1,16", bus.alu_op, bus.alu_vi, bus.alu_rd); end
        alu_cdb(5'd7, 32'd8);
        step();
        no_cdb();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL prio_gap got=%0d exp=0", bus.alu_op); end
        step();
        total++; if (bus.alu_rd !== 5'd18 || bus.alu_vi !== 32'd8 || bus.alu_vj !== 32'd2) begin
            bad++; $display("FAIL prio_first got=%0d,%0d,%0d exp=18,8,2", bus.alu_rd, bus.alu_vi, bus.alu_vj); end
        step();
        total++; if (bus.alu_rd !== 5'd21 || bus.alu_vi !== 32'd8 || bus.alu_op !== 6'd4) begin
            bad++; $display("FAIL prio_second got=%0d,%0d,%0d exp=21,8,4", bus.alu_rd, bus.alu_vi, bus.alu_op); end
        lsb_cdb(5'd12, 32'd3);
        step();
        no_cdb();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL prio_idle got=%0d exp=0", bus.alu_op); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (bus.alu_rd !== 5'(17 + 2 * k - (k == 2 ? 1 : 0)) || bus.alu_vi !== 32'd3) begin
                bad++; $display("FAIL prio_rest%0d got=%0d,%0d exp=%0d,3", k, bus.alu_rd, bus.alu_vi, 17 + 2 * k - (k == 2 ? 1 : 0)); end
        end
        step();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL prio_drain got=%0d exp=0", bus.alu_op); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            dis(6'd5, 32'd0, 32'd0, 1'b1, 5'd13, 1'b0, 5'd0, 5'(k));
            step();
        end
        dis(6'd5, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
        step();
        dis(6'd5, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4);
        alu_cdb(5'd13, 32'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        no_dis();
        total++; if (bus.alu_op !== 6'd0 || bus.full !== 1'b0) begin bad++; $display("FAIL flush_edge got=%0d,%0b exp=0,0", bus.alu_op, bus.full); end
        for (int c = 0; c < 4; c++) begin
            step();
            no_cdb();
            total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL flush_after%0d got=%0d exp=0", c, bus.alu_op); end
        end
    endtask

    task automatic test_stall_reset();
        dis(6'd6, 32'h55, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        step();
        dis(6'd7, 32'h66, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8);
        step();
        total++; if (bus.alu_op !== 6'd6) begin bad++; $display("FAIL stall_pre got=%0d exp=6", bus.alu_op); end
        rdy_in = 1'b0;
        dis(6'd8, 32'h77, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (bus.alu_op !== 6'd6 || bus.alu_vi !== 32'h55 || bus.alu_rd !== 5'd7) begin
                bad++; $display("FAIL stall_hold%0d got=%0d,%0h,%0d exp=6,55,7", c, bus.alu_op, bus.alu_vi, bus.alu_rd); end
        end
        no_dis();
        rdy_in = 1'b1;
        step();
        total++; if (bus.alu_op !== 6'd7 || bus.alu_vi !== 32'h66 || bus.alu_rd !== 5'd8) begin
            bad++; $display("FAIL stall_resume got=%0d,%0h,%0d exp=7,66,8", bus.alu_op, bus.alu_vi, bus.alu_rd); end
        step();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL stall_ignored got=%0d exp=0", bus.alu_op); end
        dis(6'd9, 32'h99, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd10);
        step();
        dis(6'd9, 32'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd11);
        step();
        no_dis();
        total++; if (bus.alu_op !== 6'd9) begin bad++; $display("FAIL rst_pre got=%0d exp=9", bus.alu_op); end
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        total++; if (bus.alu_op !== 6'd0 || bus.alu_vi !== 32'd0 || bus.alu_rd !== 5'd0 || bus.alu_pc !== 32'd0 || bus.alu_imm !== 32'd0 || bus.alu_itype !== 1'b0) begin
            bad++; $display("FAIL rst_outputs got=%0d,%0h,%0d,%0h,%0h,%0b exp=all zero", bus.alu_op, bus.alu_vi, bus.alu_rd, bus.alu_pc, bus.alu_imm, bus.alu_itype); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b exp=0", bus.full); end
        alu_cdb(5'd3, 32'd1);
        step();
        no_cdb();
        step();
        total++; if (bus.alu_op !== 6'd0) begin bad++; $display("FAIL rst_cleared got=%0d exp=0", bus.alu_op); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush  = 1'b0;
        bus.dis_valid   = 1'b0;
        bus.dis_op      = '0;
        bus.dis_vi      = '0;
        bus.dis_vj      = '0;
        bus.dis_qi_busy = 1'b0;
        bus.dis_qj_busy = 1'b0;
        bus.dis_qi      = '0;
        bus.dis_qj      = '0;
        bus.dis_imm     = '0;
        bus.dis_pc      = '0;
        bus.dis_itype   = 1'b0;
        bus.dis_rob     = '0;
        bus.alu_cdb_valid = 1'b0;
        bus.alu_cdb_tag   = '0;
        bus.alu_cdb_val   = '0;
        bus.lsb_cdb_valid = 1'b0;
        bus.lsb_cdb_tag   = '0;
        bus.lsb_cdb_val   = '0;
        test_reset();
        test_single();
        test_wakeup();
        test_fill();
        test_priority();
        test_flush();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
